// File: rtl/transmission_reciprocal.sv
`default_nettype none
// ============================================================================
//  Module      : transmission_reciprocal
//  Description : Iterative restoring divider producing round(2^22 / t_eff)
//                in Q2.14, saturated to 0xFFFF, with a sideband word that
//                travels alongside each transmission sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module transmission_reciprocal #(
    parameter int T_MIN  = 64,
    parameter int USER_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        trans_in,
    input  logic [USER_W-1:0] user_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       inv_trans,
    output logic [USER_W-1:0] user_out,
    output logic              sat
);

    localparam logic [7:0]  c_T_MIN    = 8'(T_MIN);
    localparam logic [22:0] c_ONE      = 23'h40_0000;   // 2^22
    localparam logic [4:0]  c_LAST_IT  = 5'd22;         // 23 iterations: 0..22

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_div;
    logic [8:0]        r_rem;
    logic [22:0]       r_quot;
    logic [4:0]        r_cnt;
    logic [USER_W-1:0] r_user;
    logic              r_out_valid;
    logic [15:0]       r_inv;
    logic [USER_W-1:0] r_user_out;
    logic              r_sat;

    logic [7:0]        w_t_eff;
    logic [22:0]       w_num;
    logic [8:0]        w_trial;
    logic              w_ge;
    logic [8:0]        w_rem_next;
    logic [22:0]       w_q_next;
    logic              w_last;
    logic              w_q_sat;

    // Clamp keeps the divisor away from zero and bounds the quotient.
    assign w_t_eff = (trans_in < c_T_MIN) ? c_T_MIN : trans_in;
    // Adding half the divisor to the numerator turns the floor into round-half-up.
    assign w_num   = c_ONE + {16'd0, w_t_eff[7:1]};

    // One restoring step: shift the next numerator bit into the remainder.
    // A set r_rem[8] would push the shifted value past 511, which always
    // exceeds the 8-bit divisor, so it forces a subtract.
    assign w_trial    = {r_rem[7:0], r_quot[22]};
    assign w_ge       = r_rem[8] | (w_trial >= {1'b0, r_div});
    assign w_rem_next = w_ge ? (w_trial - {1'b0, r_div}) : w_trial;
    assign w_q_next   = {r_quot[21:0], w_ge};
    assign w_last     = (r_cnt == c_LAST_IT);
    assign w_q_sat    = |w_q_next[22:16];

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign inv_trans = r_inv;
    assign user_out  = r_user_out;
    assign sat       = r_sat;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in CALC, wait for the consumer in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_CALC;
            ST_CALC: if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, division iterations and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= 8'd0;
            r_rem       <= 9'd0;
            r_quot      <= 23'd0;
            r_cnt       <= 5'd0;
            r_user      <= '0;
            r_out_valid <= 1'b0;
            r_inv       <= 16'd0;
            r_user_out  <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_div  <= w_t_eff;
                        r_rem  <= 9'd0;
                        r_quot <= w_num;
                        r_cnt  <= 5'd0;
                        r_user <= user_in;
                    end
                end
                ST_CALC: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_q_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_inv       <= w_q_sat ? 16'hFFFF : w_q_next[15:0];
                        r_sat       <= w_q_sat;
                        r_user_out  <= r_user;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
